// File: rtl/led_anim_pkg.sv
// Shared types for the LED animator: animation ids, FSM states and
// the fixed-priority event resolver.
package led_anim_pkg;

   typedef enum logic [1:0] {
      GOAL1 = 2'd0,
      GOAL2 = 2'd1,
      WIN1  = 2'd2,
      WIN2  = 2'd3
   } anim_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BLANK = 2'd2
   } state_e;

   typedef struct packed {
      logic  valid;
      anim_e id;
   } event_t;

   // edges = {win1, win2, goal1, goal2}; highest priority wins, the rest are dropped
   function automatic event_t resolve_event(input logic [3:0] edges);
      event_t ev;
      ev.valid = |edges;
      if (edges[3])      ev.id = WIN1;
      else if (edges[2]) ev.id = WIN2;
      else if (edges[1]) ev.id = GOAL1;
      else               ev.id = GOAL2;
      return ev;
   endfunction

   function automatic logic is_win(input anim_e id);
      return (id == WIN1) || (id == WIN2);
   endfunction

endpackage

// File: rtl/led_anim_frame_gen.sv
// Combinational frame lookup: maps (animation, frame index) to an LED pattern.
// Win frames past the fill phase saturate at the full pattern, which gives the hold frames.
module led_anim_frame_gen
   import led_anim_pkg::*;
#(
   parameter int LED_COUNT   = 8,
   parameter int HOLD_FRAMES = 1,
   parameter int FRAME_W     = $clog2(LED_COUNT + HOLD_FRAMES)
) (
   input  anim_e                anim_id,
   input  logic [FRAME_W-1:0]   frame,
   output logic [LED_COUNT-1:0] led
);

   localparam int H = LED_COUNT / 2;

   // Build each LED bit from the frame index
   always_comb begin
      int k;
      int j;
      led = '0;
      k   = int'(frame);
      j   = k - H + 1;
      if (j > H - 1) j = H - 1;
      for (int i = 0; i < LED_COUNT; i++) begin
         case (anim_id)
            GOAL1: led[i] = (i == LED_COUNT - 1 - k);
            GOAL2: led[i] = (i == k);
            WIN1: begin
               if (k < H) led[i] = (i == k) || (i == LED_COUNT - 1 - k);
               else       led[i] = (i >= H - 1) && (i <= H + j);
            end
            WIN2: begin
               if (k < H) led[i] = (i == k) || (i == LED_COUNT - 1 - k);
               else       led[i] = (i >= H - 1 - j) && (i <= H);
            end
            default: led[i] = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/led_animator.sv
// Scoreboard LED animator: goal sweeps and win fills on an N-LED bar.
// Optional macro LED_ANIM_QUEUE_EN adds a one-deep pending slot for goal
// events that arrive while an animation is playing.
//
// state | meaning
// IDLE  | bar dark, waiting for a goal/win edge
// RUN   | showing lit frames, each for STEP_TICKS cycles
// BLANK | bar dark for STEP_TICKS cycles closing one round
module led_animator
   import led_anim_pkg::*;
#(
   parameter int LED_COUNT   = 8,
   parameter int STEP_TICKS  = 3,
   parameter int REPEATS     = 1,
   parameter int HOLD_FRAMES = 1
) (
   input  logic                 BALL_CLOCK,
   input  logic                 RESET,
   input  logic                 goal_player_1,
   input  logic                 goal_player_2,
   input  logic                 win_player_1,
   input  logic                 win_player_2,
   output logic [LED_COUNT-1:0] led,
   output logic                 busy,
   output logic [1:0]           anim_id,
   output logic                 done
);

   localparam int TW = $clog2(STEP_TICKS + 1);
   localparam int FW = $clog2(LED_COUNT + HOLD_FRAMES);
   localparam int RW = $clog2(REPEATS + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
   localparam logic [FW-1:0] GOAL_LAST = FW'(LED_COUNT - 1);
   localparam logic [FW-1:0] WIN_LAST  = FW'(LED_COUNT - 2 + HOLD_FRAMES);
   localparam logic [RW-1:0] ROUNDS    = RW'(REPEATS);

   logic [3:0]           ev_q;
   logic [3:0]           edges;
   event_t               ev;
   state_e               state_q, state_d;
   anim_e                anim_q, anim_d;
   logic [FW-1:0]        frame_q, frame_d, last_frame;
   logic [TW-1:0]        tick_q, tick_d;
   logic [RW-1:0]        round_q, round_d;
   logic                 done_d;
   logic [LED_COUNT-1:0] led_gen;

`ifdef LED_ANIM_QUEUE_EN
   logic  pend_valid_q, pend_valid_d;
   anim_e pend_id_q, pend_id_d;
`endif

   assign edges   = {win_player_1, win_player_2, goal_player_1, goal_player_2} & ~ev_q;
   assign ev      = resolve_event(edges);
   assign anim_id = anim_q;

   led_anim_frame_gen #(
      .LED_COUNT   (LED_COUNT),
      .HOLD_FRAMES (HOLD_FRAMES),
      .FRAME_W     (FW)
   ) u_frame_gen (
      .anim_id (anim_d),
      .frame   (frame_d),
      .led     (led_gen)
   );

   // Next-state: start, preempt, frame/tick advance, round close and pending hand-off
   always_comb begin
      state_d    = state_q;
      anim_d     = anim_q;
      frame_d    = frame_q;
      tick_d     = tick_q;
      round_d    = round_q;
      done_d     = 1'b0;
      last_frame = is_win(anim_q) ? WIN_LAST : GOAL_LAST;
`ifdef LED_ANIM_QUEUE_EN
      pend_valid_d = pend_valid_q;
      pend_id_d    = pend_id_q;
`endif
      case (state_q)
         IDLE: begin
            if (ev.valid) begin
               state_d = RUN;
               anim_d  = ev.id;
               frame_d = '0;
               tick_d  = '0;
               round_d = ROUNDS;
            end
         end
         RUN, BLANK: begin
            if (ev.valid && is_win(ev.id) && !is_win(anim_q)) begin
               // win preempts a goal animation silently
               state_d = RUN;
               anim_d  = ev.id;
               frame_d = '0;
               tick_d  = '0;
               round_d = ROUNDS;
`ifdef LED_ANIM_QUEUE_EN
               pend_valid_d = 1'b0;
`endif
            end else begin
`ifdef LED_ANIM_QUEUE_EN
               if (ev.valid && !is_win(ev.id)) begin
                  pend_valid_d = 1'b1;
                  pend_id_d    = ev.id;
               end
`endif
               if (tick_q != TICK_LAST) begin
                  tick_d = tick_q + 1'b1;
               end else begin
                  tick_d = '0;
                  if (state_q == RUN) begin
                     if (frame_q == last_frame) state_d = BLANK;
                     else                       frame_d = frame_q + 1'b1;
                  end else begin
                     round_d = round_q - 1'b1;
                     frame_d = '0;
                     if (round_q > RW'(1)) begin
                        state_d = RUN;
                     end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef LED_ANIM_QUEUE_EN
                        // a goal edge in this very cycle counts as pending too
                        if (pend_valid_d) begin
                           state_d      = RUN;
                           anim_d       = pend_id_d;
                           round_d      = ROUNDS;
                           pend_valid_d = 1'b0;
                        end
`endif
                     end
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge BALL_CLOCK or posedge RESET) begin
      if (RESET) begin
         ev_q    <= '0;
         state_q <= IDLE;
         anim_q  <= GOAL1;
         frame_q <= '0;
         tick_q  <= '0;
         round_q <= '0;
         led     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         ev_q    <= {win_player_1, win_player_2, goal_player_1, goal_player_2};
         state_q <= state_d;
         anim_q  <= anim_d;
         frame_q <= frame_d;
         tick_q  <= tick_d;
         round_q <= round_d;
         led     <= (state_d == RUN) ? led_gen : '0;
         busy    <= (state_d != IDLE);
         done    <= done_d;
      end
   end

`ifdef LED_ANIM_QUEUE_EN
   // Pending goal slot
   always_ff @(posedge BALL_CLOCK or posedge RESET) begin
      if (RESET) begin
         pend_valid_q <= 1'b0;
         pend_id_q    <= GOAL1;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
      end
   end
`endif

endmodule

// File: doc/led_animator.md
Name: led_animator

Overview:
- Parametrised successor of the scoreboard LED animation block in the Pong design.
- Plays goal-sweep and win-fill animations on an N-LED bar, clocked by the ball tick clock, triggered by goal/win pulses from the score logic.
- Adds over the previous generation:
  - LED count, frame length and repeat count are parameters.
  - Events are edge-detected.
  - Events have a fixed priority, and win events preempt goal animations.
  - Status outputs busy, anim_id and done.

Parameters:
- LED_COUNT, 8: number of LEDs; even, at least 4.
- STEP_TICKS, 3: clock cycles each frame is displayed; at least 1.
- REPEATS, 1: rounds played per event; at least 1.
- HOLD_FRAMES, 1: extra frames the final win pattern is held before blanking.

Ports:
- BALL_CLOCK  in  1  ball tick clock; sole clock.
- RESET  in  1  asynchronous, active-high reset.
- goal_player_1  in  1  goal event, player 1.
- goal_player_2  in  1  goal event, player 2.
- win_player_1  in  1  win event, player 1.
- win_player_2  in  1  win event, player 2.
- led  out  LED_COUNT  LED pattern; bit LED_COUNT-1 is the leftmost LED.
- busy  out  1  high while an animation plays.
- anim_id  out  2  current animation: 0=GOAL1, 1=GOAL2, 2=WIN1, 3=WIN2; valid only while busy.
- done  out  1  one-cycle pulse when an animation completes.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: led=0, busy=0, anim_id=0, done=0.
  - Internal: edge-detect registers=0, state=IDLE, counters=0, pending slot empty.
  - Reset mid-animation aborts it immediately, with no done pulse.
- Event detection:
  - Each event input is registered.
  - An event is a cycle where the input is 1 and the registered value is 0; a held level is one event.
  - Priority on simultaneous edges: WIN1 > WIN2 > GOAL1 > GOAL2. Lower-priority edges in the same cycle are discarded.
- FSM states: IDLE, RUN, BLANK.
- IDLE -> RUN:
  - At the edge that detects an event, led loads frame 0, busy=1, anim_id is set, frame counter=0, tick counter=0, round counter=REPEATS.
  - Latency from input rise to led change is one cycle.
- RUN:
  - Each frame is held for STEP_TICKS cycles.
  - On the last tick, advance to the next frame.
  - After the last frame, go to BLANK.
- BLANK:
  - led=0 for STEP_TICKS cycles, then decrement the round counter.
  - If rounds remain, return to RUN at frame 0.
  - Otherwise pulse done and go to IDLE (busy=0), or start the pending event (see Optional Feature).
- Frames, with N=LED_COUNT and H=N/2:
  - GOAL1: frames k=0..N-1, led = 1<<(N-1-k). Sweeps left to right.
  - GOAL2: frames k=0..N-1, led = 1<<k.
  - WIN1:
    - Converge frames k=0..H-1: bits k and N-1-k set.
    - Fill frames j=1..H-1: bits H-1 through H+j set.
    - Then the final pattern is repeated for HOLD_FRAMES frames.
  - WIN2: converge frames as WIN1; fill frames j=1..H-1 set bits H-1-j through H.
  - Frames per round:
    - Goal: N lit + 1 blank.
    - Win: N-1+HOLD_FRAMES lit + 1 blank.
- Events during RUN/BLANK:
  - A win edge during a goal animation preempts it. On the next edge, restart at the win frame 0 with no done pulse, and clear the pending slot.
  - A win edge during a win animation is ignored.
  - A goal edge during any animation goes to the pending slot or is dropped (see Optional Feature).
- Arithmetic:
  - Counter widths: tick $clog2(STEP_TICKS+1), frame $clog2(N+HOLD_FRAMES), round $clog2(REPEATS+1).
  - No counter wraps; each reloads explicitly.

Optional Feature:
- Macro: LED_ANIM_QUEUE_EN.
- Defined:
  - A one-deep pending slot holds a goal event that arrives during an animation.
  - A newer goal edge overwrites the slot.
  - When the animation ends, done pulses and the pending animation starts on the same edge. busy stays 1, and frame 0 appears the next cycle.
- Undefined: goal edges during an animation are dropped, and no slot register exists.

Decomposition:
- Package led_anim_pkg: anim_e enum (GOAL1, GOAL2, WIN1, WIN2), state enum (IDLE, RUN, BLANK), priority-resolve function.
- Sub-module led_anim_frame_gen:
  - Combinational.
  - Inputs: anim_id and frame index. Output: LED pattern.
  - Parametrised by LED_COUNT and HOLD_FRAMES.

Test Plan:
- Defaults; pulse goal_player_1 1 cycle:
  - led = 0x80, 0x40 … 0x01, each for 3 cycles, then 0x00 for 3 cycles.
  - done pulses once; busy high for 27 cycles.
- win_player_2 held high 50 cycles:
  - Sequence 0x81, 0x42, 0x24, 0x18, 0x1C, 0x1E, 0x1F, 0x1F, then blank.
  - Exactly one animation plays despite the held level.
- goal_player_2 at cycle 0, win_player_1 at cycle 7:
  - led shows 0x81 at cycle 8.
  - anim_id=2; no done pulse for the goal.
- goal_player_1 and win_player_2 rise in the same cycle: WIN2 plays and the goal is discarded.
- LED_ANIM_QUEUE_EN defined; goal_player_2 arrives mid GOAL1:
  - After the GOAL1 blank, done pulses, busy stays 1, and led=0x01 follows.
  - Without the macro, the bench reaches IDLE after GOAL1.
- RESET asserted asynchronously mid-frame: led, busy and done are 0 before the next clock edge, and the next event starts cleanly at frame 0.
